// File: rtl/fifo_controller.sv
// Pointer/occupancy controller for an external single-port-per-side FIFO memory.
// Tracks EMPTY/PARTIAL/FULL, drives memory enables and reports sticky error flags.
module fifo_controller #(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  output logic                     wen,
  output logic                     ren,
  output logic [$clog2(DEPTH):0]   wrAddress,
  output logic [$clog2(DEPTH):0]   rdAddress,
  output logic                     dataValid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow,
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       push_ok;
  logic       pop_ok;

  // Push on FULL is only accepted together with a pop: the read frees the slot
  // being written, and the memory returns the old word at that same edge.
  always_comb begin
    push_ok = push && ((state != ST_FULL) || pop);
    pop_ok  = pop && (state != ST_EMPTY);
  end

  assign wen         = push_ok;
  assign ren         = pop_ok;
  assign empty       = (state == ST_EMPTY);
  assign full        = (state == ST_FULL);
  assign almost_full = (count >= AF_CNT);
  assign state_dbg   = state;

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY:   if (push_ok) state_next = ST_PARTIAL;
      ST_PARTIAL: begin
        if (push_ok && !pop_ok && count == LAST_CNT)
          state_next = ST_FULL;
        else if (pop_ok && !push_ok && count == (AW+1)'(1))
          state_next = ST_EMPTY;
      end
      ST_FULL:    if (pop_ok && !push_ok) state_next = ST_PARTIAL;
      default:    state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_EMPTY;
      wrAddress <= '0;
      rdAddress <= '0;
      count     <= '0;
      dataValid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_next;
      dataValid <= pop_ok;
      if (push_ok) wrAddress <= wrAddress + 1'b1;
      if (pop_ok)  rdAddress <= rdAddress + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow  <= 1'b1;
      if (pop && empty)         underflow <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_controller.md
FIFO_CONTROLLER -- requirements
Module: fifo_controller

Interface
REQ-001 Parameter: DEPTH, 8, number of memory entries; power of two; memory index = low log2(DEPTH) address bits.
REQ-002 Parameter: AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL.
REQ-003 Port: clock  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: push  input  1  request to write one word this cycle.
REQ-006 Port: pop  input  1  request to read one word this cycle.
REQ-007 Port: wen  output  1  memory write enable, combinational = accepted push.
REQ-008 Port: ren  output  1  memory read enable, combinational = accepted pop.
REQ-009 Port: wrAddress  output  4  write pointer; bits [2:0] index, bit 3 wrap flag.
REQ-010 Port: rdAddress  output  4  read pointer; bits [2:0] index, bit 3 wrap flag.
REQ-011 Port: dataValid  output  1  memory dataOut holds popped word; registered, one cycle after ren.
REQ-012 Port: count  output  4  stored entries, 0..8.
REQ-013 Port: empty / full / almost_full  output  1 each  occupancy flags.
REQ-014 Port: overflow / underflow  output  1 each  sticky error flags.

Function
REQ-015 State machine states SHALL be EMPTY, PARTIAL, FULL; empty = (state==EMPTY), full = (state==FULL).
REQ-016 Accepted push SHALL be push && !full, or push && pop && full.
REQ-017 Accepted pop SHALL be pop && !empty; a simultaneous push never makes a pop on EMPTY accepted (no fall-through).
REQ-018 wen SHALL equal accepted push and ren SHALL equal accepted pop in the same cycle; the memory captures dataIn / launches read at that edge.
REQ-019 On accepted push, wrAddress SHALL increment by 1 modulo 16 at the clock edge; on accepted pop, rdAddress likewise.
REQ-020 count SHALL be +1 on push-only, -1 on pop-only, unchanged on both or neither; never exceeds 8 or goes below 0.
REQ-021 Transitions: EMPTY->PARTIAL on accepted push; PARTIAL->FULL when push-only and count==7; PARTIAL->EMPTY when pop-only and count==1; FULL->PARTIAL on pop-only; push+pop holds state.
REQ-022 Invariant: FULL iff wrAddress[2:0]==rdAddress[2:0] and wrap bits differ; EMPTY iff wrAddress==rdAddress.
REQ-023 Push+pop when FULL SHALL write the slot being read in the same cycle; memory returns the old word, so no data loss.
REQ-024 dataValid SHALL be 1 exactly in the cycle after an accepted pop, else 0.
REQ-025 almost_full SHALL be combinational from count (count >= AF_LEVEL).
REQ-026 overflow SHALL set when push && full && !pop; underflow SHALL set when pop && empty; both hold until reset.
REQ-027 Rejected requests SHALL not change pointers, count, state, wen or ren.

Reset
REQ-028 While reset=1 at a clock edge: wrAddress=0, rdAddress=0, count=0, state=EMPTY, dataValid=0, overflow=0, underflow=0; push/pop ignored.
REQ-029 After reset: empty=1, full=0, almost_full=0, wen=0, ren=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; memory contents are not cleared.

Verification
REQ-031 Reset, then 8 pushes -> count 1..8, wrAddress 0..8, full=1 after 8th, almost_full=1 from count=6, overflow=0.
REQ-032 From full, 1 extra push with pop=0 -> wen=0, wrAddress stays 8, overflow=1 and stays 1 through later traffic.
REQ-033 From full, 8 pops -> ren each cycle, rdAddress 0..8, dataValid one cycle later, data 0..7 in order, empty=1 at end.
REQ-034 From empty, pop with push=1 -> ren=0, underflow=1, wen=1, count=1.
REQ-035 Continuous push+pop at count=4 for 20 cycles -> count stays 4, pointers wrap 15->0, FIFO order preserved; repeat at full, count stays 8.
REQ-036 Reset at count=5 -> next cycle count=0, empty=1, both pointers 0, error flags 0.
